// File: rtl/bnn_pkg.sv
//------------------------------------------------------------------------------
// bnn_pkg
// Shared types and helpers for the BNN output packer.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package bnn_pkg;

    typedef enum logic [1:0] {
        PK_IDLE  = 2'd0,
        PK_PACK  = 2'd1,
        PK_DRAIN = 2'd2
    } pk_state_t;

    // Number of packed words produced for one feature map.
    function automatic int words_per_map(input int word_width, input int map_width,
                                         input int map_height, input bit row_align);
        if (row_align)
            return map_height * ((map_width + word_width - 1) / word_width);
        return (map_width * map_height + word_width - 1) / word_width;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bnn_word_fifo.sv
//------------------------------------------------------------------------------
// bnn_word_fifo
// Synchronous first-word-fall-through FIFO with simultaneous push/pop.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bnn_word_fifo
    import bnn_pkg::*;
#(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_pop;
    logic             do_push;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop & ~empty;
    // A full FIFO still takes a word when a pop frees a slot in the same cycle.
    assign do_push  = push & (~full | do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

endmodule

`default_nettype wire

// File: rtl/bnn_output_packer.sv
//------------------------------------------------------------------------------
// bnn_output_packer
// Packs the serial binary activation stream LSB-first into words, buffers them
// and presents them on a ready/valid port. Optional macro
// BNN_PACKER_ROW_ALIGN_EN starts every feature-map row in a fresh word.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bnn_output_packer
    import bnn_pkg::*;
#(
    parameter int WORD_WIDTH = 32,
    parameter int MAP_WIDTH  = 32,
    parameter int MAP_HEIGHT = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  map_start,
    input  logic                  bit_valid,
    input  logic                  bit_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  map_done,
    output logic                  busy,
    output logic                  overflow
);

    localparam int TOTAL = MAP_WIDTH * MAP_HEIGHT;
    localparam int PIX_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
    localparam int BIT_W = $clog2(WORD_WIDTH);

    pk_state_t             state;
    pk_state_t             state_next;
    logic [BIT_W-1:0]      bit_cnt;
    logic [BIT_W-1:0]      bit_base;
    logic [PIX_W-1:0]      pix_cnt;
    logic [PIX_W-1:0]      pix_base;
    logic [WORD_WIDTH-1:0] shift_word;
    logic [WORD_WIDTH-1:0] word_base;
    logic [WORD_WIDTH-1:0] word_next;
    logic                  accept;
    logic                  last_pix;
    logic                  row_end;
    logic                  word_end;
    logic                  complete;
    logic                  pop;
    logic                  full;
    logic                  empty;
    logic [WORD_WIDTH:0]   fifo_rd;

    // A restart takes effect before any bit arriving in the same cycle.
    assign bit_base  = map_start ? '0 : bit_cnt;
    assign pix_base  = map_start ? '0 : pix_cnt;
    assign word_base = map_start ? '0 : shift_word;
    assign accept    = bit_valid & (map_start | (state == PK_PACK));
    assign last_pix  = (pix_base == PIX_W'(TOTAL - 1));

    always_comb begin
        word_next           = word_base;
        word_next[bit_base] = bit_in;
    end

`ifdef BNN_PACKER_ROW_ALIGN_EN
    localparam int COL_W = (MAP_WIDTH > 1) ? $clog2(MAP_WIDTH) : 1;

    logic [COL_W-1:0] col_cnt;
    logic [COL_W-1:0] col_base;

    assign col_base = map_start ? '0 : col_cnt;
    assign row_end  = (col_base == COL_W'(MAP_WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst)
            col_cnt <= '0;
        else if (accept)
            col_cnt <= row_end ? '0 : col_base + COL_W'(1);
        else if (map_start)
            col_cnt <= '0;
    end
`else
    assign row_end = 1'b0;
`endif

    assign word_end = (bit_base == BIT_W'(WORD_WIDTH - 1)) | last_pix | row_end;
    assign complete = accept & word_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt    <= '0;
            pix_cnt    <= '0;
            shift_word <= '0;
        end else if (accept) begin
            bit_cnt    <= word_end ? '0 : bit_base + BIT_W'(1);
            shift_word <= word_end ? '0 : word_next;
            pix_cnt    <= last_pix ? '0 : pix_base + PIX_W'(1);
        end else if (map_start) begin
            bit_cnt    <= '0;
            pix_cnt    <= '0;
            shift_word <= '0;
        end
    end

    bnn_word_fifo #(
        .WIDTH (WORD_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (complete),
        .push_data ({last_pix, word_next}),
        .pop       (pop),
        .pop_data  (fifo_rd),
        .full      (full),
        .empty     (empty)
    );

    assign pop       = out_ready & ~empty;
    assign out_valid = ~empty;
    assign out_data  = empty ? '0 : fifo_rd[WORD_WIDTH-1:0];
    assign out_last  = ~empty & fifo_rd[WORD_WIDTH];
    assign map_done  = (state == PK_DRAIN) & pop & fifo_rd[WORD_WIDTH];
    assign busy      = (state != PK_IDLE);

    always_ff @(posedge clk) begin
        if (rst)
            state <= PK_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        if ((state == PK_DRAIN) && map_done)
            state_next = PK_IDLE;
        if (map_start)
            state_next = PK_PACK;
        if (accept && last_pix)
            state_next = PK_DRAIN;
    end

    // Sticky loss flag: a completed word with no room, or a bit outside a map.
    always_ff @(posedge clk) begin
        if (rst)
            overflow <= 1'b0;
        else if ((complete & full & ~pop) | (bit_valid & ~accept))
            overflow <= 1'b1;
    end

endmodule

`default_nettype wire

// File: tb/tb_bnn_output_packer.sv
//------------------------------------------------------------------------------
// tb_bnn_output_packer
// Directed bench: three packer instances sharing one input stimulus.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_bnn_output_packer;

    logic clk;
    logic rst;
    logic map_start;
    logic bit_valid;
    logic bit_in;
    logic out_ready;

    logic       a_valid, a_last, a_done, a_busy, a_ovf;
    logic [7:0] a_data;
    logic       b_valid, b_last, b_done, b_busy, b_ovf;
    logic [7:0] b_data;
    logic       c_valid, c_last, c_done, c_busy, c_ovf;
    logic [7:0] c_data;

    int n_cmp  = 0;
    int n_fail = 0;

    // A: 4x4 map, depth 4.  B: 3x3 map, depth 4.  C: 8x4 map, depth 2.
    bnn_output_packer #(.WORD_WIDTH(8), .MAP_WIDTH(4), .MAP_HEIGHT(4), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .rst(rst), .map_start(map_start), .bit_valid(bit_valid), .bit_in(bit_in),
        .out_valid(a_valid), .out_ready(out_ready), .out_data(a_data), .out_last(a_last),
        .map_done(a_done), .busy(a_busy), .overflow(a_ovf));

    bnn_output_packer #(.WORD_WIDTH(8), .MAP_WIDTH(3), .MAP_HEIGHT(3), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .rst(rst), .map_start(map_start), .bit_valid(bit_valid), .bit_in(bit_in),
        .out_valid(b_valid), .out_ready(out_ready), .out_data(b_data), .out_last(b_last),
        .map_done(b_done), .busy(b_busy), .overflow(b_ovf));

    bnn_output_packer #(.WORD_WIDTH(8), .MAP_WIDTH(8), .MAP_HEIGHT(4), .FIFO_DEPTH(2)) dut_c (
        .clk(clk), .rst(rst), .map_start(map_start), .bit_valid(bit_valid), .bit_in(bit_in),
        .out_valid(c_valid), .out_ready(out_ready), .out_data(c_data), .out_last(c_last),
        .map_done(c_done), .busy(c_busy), .overflow(c_ovf));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         sel;
        logic       rst, ms, bv, b, rdy;
        logic       ev;
        logic [7:0] ed;
        logic       el, edone, ebusy, eovf;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int sel, input logic r, input logic ms, input logic bv,
                       input logic b, input logic rdy, input logic ev, input logic [7:0] ed,
                       input logic el, input logic edone, input logic ebusy, input logic eovf);
        vec_t v;
        v.sel = sel; v.rst = r; v.ms = ms; v.bv = bv; v.b = b; v.rdy = rdy;
        v.ev = ev; v.ed = ed; v.el = el; v.edone = edone; v.ebusy = ebusy; v.eovf = eovf;
        vecs.push_back(v);
    endtask

    task automatic patch(input int idx, input logic ev, input logic [7:0] ed,
                         input logic el, input logic edone);
        vecs[idx].ev = ev; vecs[idx].ed = ed; vecs[idx].el = el; vecs[idx].edone = edone;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic get(input int sel, output logic v, output logic [7:0] d, output logic l,
                       output logic dn, output logic bz, output logic ov);
        case (sel)
            0:       begin v = a_valid; d = a_data; l = a_last; dn = a_done; bz = a_busy; ov = a_ovf; end
            1:       begin v = b_valid; d = b_data; l = b_last; dn = b_done; bz = b_busy; ov = b_ovf; end
            default: begin v = c_valid; d = c_data; l = c_last; dn = c_done; bz = c_busy; ov = c_ovf; end
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; map_start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic       v, l, dn, bz, ov;
        logic [7:0] d;
        logic [7:0] bits1;
        logic [7:0] words [4];
        logic [15:0] pat;
        logic [8:0] got [$];
        logic [8:0] expw [$];
        int base;

        rst = 1'b1; map_start = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; out_ready = 1'b1;

        // 4x4 map: 0x8D then 0x00 with last; map_done with the second handshake
        bits1 = 8'h8D;
        add(0, 1, 0, 0, 0, 1, 0, 8'h00, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 1, 0, 8'h00, 0, 0, 1, 0);
        base = vecs.size();
        for (int i = 0; i < 16; i++) begin
            if (i == 7)
                add(0, 0, 0, 1, bits1[7], 1, 1, 8'h8D, 0, 0, 1, 0);
            else if (i == 15)
                add(0, 0, 0, 1, 1'b0, 1, 1, 8'h00, 1, 1, 1, 0);
            else
                add(0, 0, 0, 1, (i < 8) ? bits1[i] : 1'b0, 1, 0, 8'h00, 0, 0, 1, 0);
        end
        add(0, 0, 0, 0, 0, 1, 0, 8'h00, 0, 0, 0, 0);
`ifdef BNN_PACKER_ROW_ALIGN_EN
        patch(base + 3,  1, 8'h0D, 0, 0);
        patch(base + 7,  1, 8'h08, 0, 0);
        patch(base + 11, 1, 8'h00, 0, 0);
`endif

        // 3x3 map of all ones
        add(1, 1, 0, 0, 0, 1, 0, 8'h00, 0, 0, 0, 0);
        add(1, 0, 1, 0, 0, 1, 0, 8'h00, 0, 0, 1, 0);
        base = vecs.size();
        for (int i = 0; i < 9; i++) begin
            if (i == 7)
                add(1, 0, 0, 1, 1, 1, 1, 8'hFF, 0, 0, 1, 0);
            else if (i == 8)
                add(1, 0, 0, 1, 1, 1, 1, 8'h01, 1, 1, 1, 0);
            else
                add(1, 0, 0, 1, 1, 1, 0, 8'h00, 0, 0, 1, 0);
        end
        add(1, 0, 0, 0, 0, 1, 0, 8'h00, 0, 0, 0, 0);
`ifdef BNN_PACKER_ROW_ALIGN_EN
        patch(base + 2, 1, 8'h07, 0, 0);
        patch(base + 5, 1, 8'h07, 0, 0);
        patch(base + 7, 0, 8'h00, 0, 0);
        patch(base + 8, 1, 8'h07, 1, 1);
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; map_start = vecs[i].ms; bit_valid = vecs[i].bv;
            bit_in = vecs[i].b; out_ready = vecs[i].rdy;
            tick();
            get(vecs[i].sel, v, d, l, dn, bz, ov);
            check($sformatf("vec%0d out_valid", i), 32'(v), 32'(vecs[i].ev));
            if (vecs[i].ev) begin
                check($sformatf("vec%0d out_data", i), 32'(d), 32'(vecs[i].ed));
                check($sformatf("vec%0d out_last", i), 32'(l), 32'(vecs[i].el));
            end
            check($sformatf("vec%0d map_done", i), 32'(dn), 32'(vecs[i].edone));
            check($sformatf("vec%0d busy", i), 32'(bz), 32'(vecs[i].ebusy));
            check($sformatf("vec%0d overflow", i), 32'(ov), 32'(vecs[i].eovf));
        end

        // Backpressure: depth-2 FIFO, 4 words streamed with out_ready low
        do_reset();
        out_ready = 1'b0;
        words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hFF; words[3] = 8'h81;
        map_start = 1'b1;
        tick();
        map_start = 1'b0;
        for (int w = 0; w < 4; w++) begin
            for (int b = 0; b < 8; b++) begin
                bit_valid = 1'b1; bit_in = words[w][b];
                tick();
                check($sformatf("bp ovf bit%0d", w * 8 + b), 32'(c_ovf), 32'((w * 8 + b + 1) >= 24));
                if (w == 0 && b == 7) begin
                    check("bp first valid", 32'(c_valid), 32'd1);
                    check("bp first data", 32'(c_data), 32'hA5);
                end
            end
        end
        bit_valid = 1'b0;
        tick();
        check("bp held data", 32'(c_data), 32'hA5);
        check("bp held busy", 32'(c_busy), 32'd1);
        out_ready = 1'b1;
        #1;
        check("bp word0 valid", 32'(c_valid), 32'd1);
        check("bp word0 last", 32'(c_last), 32'd0);
        tick();
        check("bp word1 valid", 32'(c_valid), 32'd1);
        check("bp word1 data", 32'(c_data), 32'h3C);
        check("bp word1 last", 32'(c_last), 32'd0);
        check("bp word1 done", 32'(c_done), 32'd0);
        tick();
        check("bp drained valid", 32'(c_valid), 32'd0);
        check("bp drained busy", 32'(c_busy), 32'd1);

        // Abort after 5 bits, then restart carrying pixel 0 in the same cycle
        do_reset();
        out_ready = 1'b1;
        map_start = 1'b1;
        tick();
        map_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bit_valid = 1'b1; bit_in = 1'b1;
            tick();
        end
        check("abort no word", 32'(a_valid), 32'd0);
        pat = 16'hC33C;
        for (int i = 0; i < 20; i++) begin
            map_start = (i == 0);
            bit_valid = (i < 16);
            bit_in    = (i < 16) ? pat[i] : 1'b0;
            tick();
            if (a_valid) begin
                got.push_back({a_last, a_data});
                if (a_last)
                    check("abort map_done", 32'(a_done), 32'd1);
            end
        end
        map_start = 1'b0; bit_valid = 1'b0;
`ifdef BNN_PACKER_ROW_ALIGN_EN
        expw = '{9'h00C, 9'h003, 9'h003, 9'h10C};
`else
        expw = '{9'h03C, 9'h1C3};
`endif
        check("abort word count", 32'(got.size()), 32'(expw.size()));
        for (int i = 0; i < expw.size() && i < got.size(); i++)
            check($sformatf("abort word%0d", i), 32'(got[i]), 32'(expw[i]));
        check("abort idle", 32'(a_busy), 32'd0);
        check("abort no ovf", 32'(a_ovf), 32'd0);

        // Stray bit in IDLE, then a one-cycle reset
        do_reset();
        bit_valid = 1'b1; bit_in = 1'b1;
        tick();
        bit_valid = 1'b0;
        check("stray ovf", 32'(a_ovf), 32'd1);
        check("stray valid", 32'(a_valid), 32'd0);
        check("stray busy", 32'(a_busy), 32'd0);
        tick();
        check("stray fifo empty", 32'(a_valid), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst ovf", 32'(a_ovf), 32'd0);
        check("rst valid", 32'(a_valid), 32'd0);
        check("rst data", 32'(a_data), 32'd0);
        check("rst last", 32'(a_last), 32'd0);
        check("rst done", 32'(a_done), 32'd0);
        check("rst busy", 32'(a_busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
